// File: rtl/mem_cycle_sequencer_pkg.sv
// Shared types and defaults for the core-memory cycle sequencer.
// Phase encoding, owner codes and default phase lengths.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      READ    = 3'd2,
      SENSE   = 3'd3,
      WRITE   = 3'd4,
      RECOVER = 3'd5
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DA  = 1'b1;

   localparam int DEF_READ_LEN   = 4;
   localparam int DEF_WRITE_LEN  = 4;
   localparam int DEF_RECOV_LEN  = 2;
   localparam int DEF_STARVE_MAX = 3;

   // Largest of three phase lengths; sizes the shared phase counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/mem_cycle_sequencer_arbiter.sv
// CPU / data adapter arbitration with a starvation guard for the CPU.
// The data adapter is favoured until the CPU has waited STARVE_MAX grants.
module mem_req_arbiter
   import mem_seq_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic da_req,
   input  logic arb_en,
   output logic winner,
   output logic valid
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_r;
   logic [SW-1:0] starve_nxt_s;
   logic          starved_s;
   logic          winner_s;

   assign starved_s = (starve_r == SW'(STARVE_MAX));
   assign winner    = winner_s;
   assign valid     = arb_en & (cpu_req | da_req);

   // Winner selection and next starvation count.
   always_comb begin
      winner_s     = OWN_CPU;
      starve_nxt_s = starve_r;
      if (cpu_req & da_req) begin
         winner_s = starved_s ? OWN_CPU : OWN_DA;
      end else if (da_req) begin
         winner_s = OWN_DA;
      end else begin
         winner_s = OWN_CPU;
      end
      if (arb_en) begin
         if (!cpu_req) begin
            starve_nxt_s = {SW{1'b0}};
         end else if (da_req && (winner_s == OWN_DA)) begin
            starve_nxt_s = starved_s ? starve_r : (starve_r + SW'(1));
         end else begin
            starve_nxt_s = {SW{1'b0}};
         end
      end else begin
         starve_nxt_s = starve_r;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_r <= {SW{1'b0}};
      end else begin
         starve_r <= starve_nxt_s;
      end
   end

endmodule

// File: rtl/mem_cycle_sequencer.sv
// One core-memory cycle at a time: select, destructive read, sense, write/restore,
// recovery; drives the module-select and drive strobes. Outputs are registered.
module mem_cycle_sequencer
   import mem_seq_pkg::*;
#(
   parameter int READ_LEN   = DEF_READ_LEN,
   parameter int WRITE_LEN  = DEF_WRITE_LEN,
   parameter int RECOV_LEN  = DEF_RECOV_LEN,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_req,
   input  logic cpu_wr,
   input  logic cpu_sel_b,
   input  logic da_req,
   input  logic da_wr,
   input  logic da_sel_b,
   input  logic duplex,
   input  logic cmp_err,
   input  logic err_clr,
   output logic cpu_gnt,
   output logic da_gnt,
   output logic owner,
   output logic mao,
   output logic mbo,
   output logic rd,
   output logic strobe,
   output logic inhbs,
   output logic wdata_en,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int PW = $clog2(max3(READ_LEN, WRITE_LEN, RECOV_LEN) + 1);

   state_t        state_r, state_nxt_s;
   logic [PW-1:0] cnt_r, cnt_nxt_s;
   logic          own_r, own_nxt_s;
   logic          wr_r, wr_nxt_s;
   logic          selb_r, selb_nxt_s;
   logic          dup_r, dup_nxt_s;
   logic          err_r;
   logic          arb_en_s, arb_valid_s, arb_winner_s;
   logic          cnt_zero_s;

   logic cpu_gnt_r, da_gnt_r, owner_r, mao_r, mbo_r, rd_r, strobe_r;
   logic inhbs_r, wdata_en_r, busy_r, done_r;
   logic cpu_gnt_d, da_gnt_d, owner_d, mao_d, mbo_d, rd_d, strobe_d;
   logic inhbs_d, wdata_en_d, busy_d, done_d, sel_d;

   assign cnt_zero_s = (cnt_r == {PW{1'b0}});
   assign arb_en_s   = (state_r == IDLE) | ((state_r == RECOVER) & cnt_zero_s);

   mem_req_arbiter #(
      .STARVE_MAX(STARVE_MAX)
   ) u_arb (
      .clk    (clk),
      .rst    (reset),
      .cpu_req(cpu_req),
      .da_req (da_req),
      .arb_en (arb_en_s),
      .winner (arb_winner_s),
      .valid  (arb_valid_s)
   );

   // Phase sequencing; the winner's attributes are captured on entry to SELECT.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      own_nxt_s   = own_r;
      wr_nxt_s    = wr_r;
      selb_nxt_s  = selb_r;
      dup_nxt_s   = dup_r;
      case (state_r)
         IDLE, RECOVER: begin
            if ((state_r == RECOVER) && !cnt_zero_s) begin
               cnt_nxt_s = cnt_r - PW'(1);
            end else if (arb_valid_s) begin
               state_nxt_s = SELECT;
               own_nxt_s   = arb_winner_s;
               wr_nxt_s    = (arb_winner_s == OWN_DA) ? da_wr : cpu_wr;
               selb_nxt_s  = (arb_winner_s == OWN_DA) ? da_sel_b : cpu_sel_b;
               dup_nxt_s   = duplex;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SELECT: begin
            state_nxt_s = READ;
            cnt_nxt_s   = PW'(READ_LEN - 1);
         end
         READ: begin
            if (cnt_zero_s) begin
               state_nxt_s = SENSE;
            end else begin
               cnt_nxt_s = cnt_r - PW'(1);
            end
         end
         SENSE: begin
            state_nxt_s = WRITE;
            cnt_nxt_s   = PW'(WRITE_LEN - 1);
         end
         WRITE: begin
            if (cnt_zero_s) begin
               state_nxt_s = RECOVER;
               cnt_nxt_s   = PW'(RECOV_LEN - 1);
            end else begin
               cnt_nxt_s = cnt_r - PW'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {PW{1'b0}};
         end
      endcase
   end

   // Output decode from the next state so the registered strobes line up with the phase.
   always_comb begin
      sel_d      = (state_nxt_s == SELECT) | (state_nxt_s == READ) |
                   (state_nxt_s == SENSE)  | (state_nxt_s == WRITE);
      busy_d     = (state_nxt_s != IDLE);
      cpu_gnt_d  = (state_nxt_s == SELECT) & (own_nxt_s == OWN_CPU);
      da_gnt_d   = (state_nxt_s == SELECT) & (own_nxt_s == OWN_DA);
      owner_d    = busy_d & own_nxt_s;
      mao_d      = sel_d & (dup_nxt_s | ~selb_nxt_s);
      mbo_d      = sel_d & (dup_nxt_s | selb_nxt_s);
      rd_d       = (state_nxt_s == READ);
      strobe_d   = (state_nxt_s == SENSE);
      inhbs_d    = (state_nxt_s == WRITE);
      wdata_en_d = (state_nxt_s == WRITE) & wr_nxt_s;
      done_d     = (state_nxt_s == RECOVER) & (cnt_nxt_s == {PW{1'b0}});
   end

   // Sequencer state, captured cycle attributes and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= {PW{1'b0}};
         own_r      <= OWN_CPU;
         wr_r       <= 1'b0;
         selb_r     <= 1'b0;
         dup_r      <= 1'b0;
         cpu_gnt_r  <= 1'b0;
         da_gnt_r   <= 1'b0;
         owner_r    <= 1'b0;
         mao_r      <= 1'b0;
         mbo_r      <= 1'b0;
         rd_r       <= 1'b0;
         strobe_r   <= 1'b0;
         inhbs_r    <= 1'b0;
         wdata_en_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         own_r      <= own_nxt_s;
         wr_r       <= wr_nxt_s;
         selb_r     <= selb_nxt_s;
         dup_r      <= dup_nxt_s;
         cpu_gnt_r  <= cpu_gnt_d;
         da_gnt_r   <= da_gnt_d;
         owner_r    <= owner_d;
         mao_r      <= mao_d;
         mbo_r      <= mbo_d;
         rd_r       <= rd_d;
         strobe_r   <= strobe_d;
         inhbs_r    <= inhbs_d;
         wdata_en_r <= wdata_en_d;
         busy_r     <= busy_d;
         done_r     <= done_d;
      end
   end

   // Sticky duplex miscompare; a set in the same clock as a clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if ((state_r == SENSE) && dup_r && cmp_err) begin
         err_r <= 1'b1;
      end else if (err_clr) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end

   assign cpu_gnt  = cpu_gnt_r;
   assign da_gnt   = da_gnt_r;
   assign owner    = owner_r;
   assign mao      = mao_r;
   assign mbo      = mbo_r;
   assign rd       = rd_r;
   assign strobe   = strobe_r;
   assign inhbs    = inhbs_r;
   assign wdata_en = wdata_en_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Bench for mem_cycle_sequencer: directed steps plus random traffic, checked against
// a cycle-offset reference model (offset k counted from the grant clock).
module tb_mem_cycle_sequencer;

   localparam int RL   = 4;
   localparam int WL   = 4;
   localparam int CL   = 2;
   localparam int SMAX = 3;
   localparam int T    = 1 + RL + 1 + WL + CL;

   logic clk = 1'b0;
   logic reset;
   logic cpu_req, cpu_wr, cpu_sel_b, da_req, da_wr, da_sel_b;
   logic duplex, cmp_err, err_clr;
   logic cpu_gnt, da_gnt, owner, mao, mbo, rd, strobe, inhbs, wdata_en, busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: one memory cycle is an offset k = 0..T-1 from its grant
   bit m_busy;
   int m_k;
   bit m_own, m_wr, m_selb, m_dup, m_err;
   int m_starve;
   bit cpu_keep, da_keep;
   int gnt_log[$];

   always #5 clk = ~clk;

   mem_cycle_sequencer #(
      .READ_LEN(RL), .WRITE_LEN(WL), .RECOV_LEN(CL), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_sel_b(cpu_sel_b),
      .da_req(da_req), .da_wr(da_wr), .da_sel_b(da_sel_b),
      .duplex(duplex), .cmp_err(cmp_err), .err_clr(err_clr),
      .cpu_gnt(cpu_gnt), .da_gnt(da_gnt), .owner(owner),
      .mao(mao), .mbo(mbo), .rd(rd), .strobe(strobe), .inhbs(inhbs),
      .wdata_en(wdata_en), .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] dut_vec();
      return {cpu_gnt, da_gnt, owner & m_busy, mao, mbo, rd, strobe, inhbs,
              wdata_en, busy, done, err};
   endfunction

   function automatic logic [11:0] model_vec();
      bit sel, ih;
      sel = m_busy && (m_k <= RL + 1 + WL);
      ih  = m_busy && (m_k >= RL + 2) && (m_k <= RL + 1 + WL);
      return {m_busy && m_k == 0 && !m_own,
              m_busy && m_k == 0 && m_own,
              m_busy && m_own,
              sel && (m_dup || !m_selb),
              sel && (m_dup || m_selb),
              m_busy && m_k >= 1 && m_k <= RL,
              m_busy && m_k == RL + 1,
              ih,
              ih && m_wr,
              m_busy,
              m_busy && m_k == T - 1,
              m_err};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_k = 0; m_own = 0; m_wr = 0; m_selb = 0; m_dup = 0;
      m_err = 0; m_starve = 0;
   endtask

   // advance the model by one rising edge using the inputs present before it
   task automatic model_step();
      bit win;
      if (m_busy && m_k == RL + 1 && m_dup && cmp_err) m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_busy && m_k != T - 1) begin
         m_k++;
      end else if (cpu_req || da_req) begin
         if (cpu_req && da_req) win = (m_starve == SMAX) ? 1'b0 : 1'b1;
         else win = da_req;
         if (!cpu_req) m_starve = 0;
         else if (win) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
         else m_starve = 0;
         m_own  = win;
         m_wr   = win ? da_wr : cpu_wr;
         m_selb = win ? da_sel_b : cpu_sel_b;
         m_dup  = duplex;
         m_busy = 1;
         m_k    = 0;
      end else begin
         m_busy   = 0;
         m_starve = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check($sformatf("outputs k=%0d", m_k), {20'd0, dut_vec()}, {20'd0, model_vec()});
      if (cpu_gnt) gnt_log.push_back(0);
      if (da_gnt)  gnt_log.push_back(1);
      if (m_busy && m_k == 0) begin
         if (!m_own && !cpu_keep) cpu_req = 1'b0;
         if (m_own && !da_keep)   da_req  = 1'b0;
      end
   endtask

   task automatic wait_k(input int k);
      bit found = 0;
      for (int i = 0; i < 60; i++) begin
         if (m_busy && m_k == k) begin found = 1; break; end
         tick();
      end
      check($sformatf("reach offset %0d", k), {31'd0, found}, 32'd1);
   endtask

   task automatic wait_idle();
      bit found = 0;
      for (int i = 0; i < 60; i++) begin
         if (!m_busy) begin found = 1; break; end
         tick();
      end
      check("reach idle", {31'd0, found}, 32'd1);
   endtask

   initial begin
      bit exp_order[8] = '{1, 1, 1, 0, 1, 1, 1, 0};
      reset = 1; cpu_req = 0; cpu_wr = 0; cpu_sel_b = 0; da_req = 0; da_wr = 0;
      da_sel_b = 0; duplex = 0; cmp_err = 0; err_clr = 0; cpu_keep = 0; da_keep = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset outputs", {20'd0, dut_vec()}, 32'd0);
      reset = 0;

      // CPU simplex read, DA idle
      cpu_req = 1; cpu_wr = 0; cpu_sel_b = 0;
      tick();
      check("cpu gnt at g", {31'd0, cpu_gnt}, 32'd1);
      repeat (T - 1) tick();
      check("done at g+11", {31'd0, done}, 32'd1);
      tick();
      check("busy low at g+12", {31'd0, busy}, 32'd0);

      // DA write to B while the CPU waits
      da_req = 1; da_wr = 1; da_sel_b = 1; cpu_req = 1; cpu_wr = 1; cpu_sel_b = 0;
      tick();
      check("da gnt", {31'd0, da_gnt}, 32'd1);
      repeat (RL + 2) tick();
      check("da write mao/mbo/wden", {29'd0, mao, mbo, wdata_en}, 32'd3);
      repeat (T - 1 - (RL + 2)) tick();
      tick();
      check("cpu gnt at g+12", {31'd0, cpu_gnt}, 32'd1);
      wait_idle();

      // both requesting continuously
      cpu_keep = 1; da_keep = 1; cpu_req = 1; da_req = 1;
      gnt_log.delete();
      repeat (8 * T) tick();
      check("grant count", gnt_log.size(), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < gnt_log.size())
            check($sformatf("grant order %0d", i), gnt_log[i], {31'd0, exp_order[i]});
      cpu_keep = 0; da_keep = 0; cpu_req = 0; da_req = 0;
      wait_idle();

      // duplex miscompare and sticky error
      cpu_req = 1; cpu_wr = 0; duplex = 1;
      wait_k(RL + 1);
      check("duplex mao/mbo", {30'd0, mao, mbo}, 32'd3);
      cmp_err = 1; tick(); cmp_err = 0;
      check("err set", {31'd0, err}, 32'd1);
      wait_idle();
      cpu_req = 1;
      wait_k(RL + 1);
      cmp_err = 1; err_clr = 1; tick(); cmp_err = 0; err_clr = 0;
      check("set beats clear", {31'd0, err}, 32'd1);
      wait_idle();
      cpu_req = 1; duplex = 0;
      wait_k(RL + 1);
      cmp_err = 1; tick(); cmp_err = 0;
      check("simplex ignores cmp", {31'd0, err}, 32'd1);
      wait_idle();
      err_clr = 1; tick(); err_clr = 0;
      check("err clear", {31'd0, err}, 32'd0);

      // asynchronous reset in mid-READ
      cpu_req = 1;
      wait_k(2);
      #2 reset = 1;
      #1 check("async reset outputs", {20'd0, dut_vec()}, 32'd0);
      model_reset();
      cpu_req = 1;
      @(negedge clk);
      check("held reset outputs", {20'd0, dut_vec()}, 32'd0);
      reset = 0;
      tick();
      check("gnt after reset", {31'd0, cpu_gnt}, 32'd1);
      wait_idle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (!cpu_req) begin
            cpu_req = ($urandom_range(0, 2) == 0);
            cpu_wr = $urandom_range(0, 1); cpu_sel_b = $urandom_range(0, 1);
         end
         if (!da_req) begin
            da_req = ($urandom_range(0, 2) == 0);
            da_wr = $urandom_range(0, 1); da_sel_b = $urandom_range(0, 1);
         end
         cpu_keep = ($urandom_range(0, 3) == 0);
         da_keep  = ($urandom_range(0, 3) == 0);
         duplex   = $urandom_range(0, 1);
         cmp_err  = ($urandom_range(0, 3) == 0);
         err_clr  = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
